valor_inmediato: RTL and testbench

- RV32I immediate generator for the decode stage of the rv32i core.
- Extracts and sign-extends the immediate field of a 32-bit instruction according to a 3-bit format selector (I, S, B, U, J).
- Registers the result for one-cycle latency, with a valid flag and an illegal-format flag.
- Consumed by the ALU operand mux and the branch/jump target adder.

---
 rtl/valor_inmediato.sv | 61 ++++++
 tb/tb_valor_inmediato.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/valor_inmediato.sv
// RV32I immediate generator: extracts and sign-extends the I/S/B/U/J immediate
// of an instruction word and registers it with valid and illegal-format flags.
module valor_inmediato (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] inst,
  input  logic [2:0]  tipo,
  output logic [31:0] inmediato,
  output logic        valido,
  output logic        tipo_invalido
);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_U = 3'b011,
    FMT_J = 3'b100
  } fmt_e;

  logic        sign;
  logic [31:0] imm_next;
  logic        illegal_next;

  assign sign = inst[31];

  // Each arm touches only its own immediate bits, so unknowns elsewhere in
  // the word cannot reach the result.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    imm_next     = '0;
    illegal_next = 1'b0;
    case (tipo)
      FMT_I:   imm_next = {{20{sign}}, inst[31:20]};
      FMT_S:   imm_next = {{20{sign}}, inst[31:25], inst[11:7]};
      FMT_B:   imm_next = {{19{sign}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm_next = {inst[31:12], 12'b0};
      FMT_J:   imm_next = {{11{sign}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      inmediato     <= '0;
      valido        <= 1'b0;
      tipo_invalido <= 1'b0;
    end else if (en) begin
      inmediato     <= imm_next;
      valido        <= 1'b1;
      tipo_invalido <= illegal_next;
    end else begin
      valido        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_valor_inmediato.sv
// Directed, table-driven bench for valor_inmediato: hand-computed immediates,
// random filler in the non-immediate bits, plus reset/enable/illegal sequences.
module tb_valor_inmediato;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] inst;
  logic [2:0]  tipo;
  logic [31:0] inmediato;
  logic        valido;
  logic        tipo_invalido;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [2:0]  tipo;
    logic [31:0] imm;      // immediate value to encode into the instruction
    logic [31:0] exp;      // hand-computed expected inmediato
    logic        exp_inv;  // expected tipo_invalido
  } vec_t;

  vec_t vecs[$];

  valor_inmediato dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .inst          (inst),
    .tipo          (tipo),
    .inmediato     (inmediato),
    .valido        (valido),
    .tipo_invalido (tipo_invalido)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] e_imm, input logic e_val, input logic e_inv);
    check({name, ".inmediato"}, inmediato, e_imm);
    check({name, ".valido"}, {31'b0, valido}, {31'b0, e_val});
    check({name, ".tipo_invalido"}, {31'b0, tipo_invalido}, {31'b0, e_inv});
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit past the rising edge.
  task automatic step(input logic r, input logic e, input logic [2:0] t, input logic [31:0] i);
    @(negedge clk);
    rst  = r;
    en   = e;
    tipo = t;
    inst = i;
    @(posedge clk);
    #1;
  endtask

  // Instruction encoders: place an immediate value into its format's fields.
  function automatic logic [31:0] encode(input logic [2:0] t, input logic [31:0] v);
    case (t)
      3'b000:  encode = {v[11:0], 20'b0};
      3'b001:  encode = {v[11:5], 13'b0, v[4:0], 7'b0};
      3'b010:  encode = {v[12], v[10:5], 13'b0, v[4:1], v[11], 7'b0};
      3'b011:  encode = {v[31:12], 12'b0};
      3'b100:  encode = {v[20], v[10:1], v[11], v[19:12], 12'b0};
      default: encode = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(input logic [2:0] t);
    case (t)
      3'b000:         imm_mask = 32'hFFF0_0000;
      3'b001, 3'b010: imm_mask = 32'hFE00_0F80;
      3'b011, 3'b100: imm_mask = 32'hFFFF_F000;
      default:        imm_mask = 32'h0;
    endcase
  endfunction

  task automatic add(input string n, input logic [2:0] t, input logic [31:0] v, input logic [31:0] e, input logic inv);
    vec_t x;
    x.name = n; x.tipo = t; x.imm = v; x.exp = e; x.exp_inv = inv;
    vecs.push_back(x);
  endtask

  initial begin
    logic [31:0] fill;
    logic [31:0] word;

    add("i_pos2000",  3'b000, 32'h0000_07D0, 32'h0000_07D0, 1'b0);
    add("i_neg2000",  3'b000, 32'hFFFF_F830, 32'hFFFF_F830, 1'b0);
    add("i_minus1",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    add("s_pos2000",  3'b001, 32'h0000_07D0, 32'h0000_07D0, 1'b0);
    add("s_neg2000",  3'b001, 32'hFFFF_F830, 32'hFFFF_F830, 1'b0);
    add("b_pos3000",  3'b010, 32'h0000_0BB8, 32'h0000_0BB8, 1'b0);
    add("b_neg3000",  3'b010, 32'hFFFF_F448, 32'hFFFF_F448, 1'b0);
    add("b_max",      3'b010, 32'h0000_0FFE, 32'h0000_0FFE, 1'b0);
    add("b_minus2",   3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);
    add("u_pos",      3'b011, 32'h0006_4000, 32'h0006_4000, 1'b0);
    add("u_neg",      3'b011, 32'hFFF9_C000, 32'hFFF9_C000, 1'b0);
    add("j_pos1e6",   3'b100, 32'h000F_4240, 32'h000F_4240, 1'b0);
    add("j_neg1e6",   3'b100, 32'hFFF0_BDC0, 32'hFFF0_BDC0, 1'b0);
    add("j_minus2",   3'b100, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);
    add("ill_101",    3'b101, 32'h0,         32'h0,         1'b1);
    add("ill_110",    3'b110, 32'h0,         32'h0,         1'b1);
    add("ill_111",    3'b111, 32'h0,         32'h0,         1'b1);

    rst = 1'b1; en = 1'b1; tipo = 3'b000; inst = 32'h0;

    // Reset held for two edges with a live capture request on the inputs.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 3'b000, $urandom() | 32'h7D00_0000);
      check_out($sformatf("reset%0d", k), 32'h0, 1'b0, 1'b0);
    end

    // Streaming: en stays high, one vector captured per edge, two passes
    // with complementary filler in the non-immediate bits.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < vecs.size(); k++) begin
        fill = $urandom();
        if (pass == 1) fill = ~fill;
        word = (fill & ~imm_mask(vecs[k].tipo)) | encode(vecs[k].tipo, vecs[k].imm);
        step(1'b0, 1'b1, vecs[k].tipo, word);
        check_out($sformatf("%s_p%0d", vecs[k].name, pass), vecs[k].exp, 1'b1, vecs[k].exp_inv);
      end
    end

    // Hold after a legal capture while inputs change to an illegal format.
    step(1'b0, 1'b1, 3'b000, 32'h8300_0000 | ($urandom() & 32'h000F_FFFF));
    check_out("hold_load", 32'hFFFF_F830, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 3'b101, $urandom());
      check_out($sformatf("hold_legal%0d", k), 32'hFFFF_F830, 1'b0, 1'b0);
    end

    // Hold after an illegal capture while inputs present a legal format.
    step(1'b0, 1'b1, 3'b110, $urandom());
    check_out("hold_ill_load", 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 3'b000, 32'h7D00_0000);
      check_out($sformatf("hold_ill%0d", k), 32'h0, 1'b0, 1'b1);
    end

    // Reset wins over en, then normal capture resumes.
    step(1'b0, 1'b1, 3'b011, 32'h0006_4000 | ($urandom() & 32'h0000_0FFF));
    check_out("prio_load", 32'h0006_4000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'b111, $urandom());
    check_out("prio_ill", 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 3'b011, 32'hFFF9_C000);
    check_out("prio_rst", 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b100, encode(3'b100, 32'h000F_4240) | ($urandom() & 32'h0000_0FFF));
    check_out("after_rst", 32'h000F_4240, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'h0);
    check_out("after_rst_idle", 32'h000F_4240, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
